// File: rtl/codes_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : codes (package)
//  Description : Shared types for the MIPS bus interface unit: transfer
//                size, bus FSM state, request source, and a big-endian
//                byte-swap helper.
//  Revision    : 1.0  initial release
// ============================================================================
package codes;

  // Transfer size as presented by the core
  typedef enum logic [1:0] {
    BYTE = 2'b00,
    HALF = 2'b01,
    WORD = 2'b10
  } bus_size_t;

  // Bus unit FSM states
  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCESS = 2'b01,
    RESP   = 2'b10
  } bus_state_t;

  // Which requester owns the current transfer
  typedef enum logic {
    SRC_FETCH = 1'b0,
    SRC_DATA  = 1'b1
  } bus_src_t;

  // Swap between bus lane order (lane k at bits 8k+7:8k) and a
  // big-endian word {lane0,lane1,lane2,lane3}
  function automatic logic [31:0] bswap32(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

endpackage
`default_nettype wire

// File: rtl/bus_lane_steer.sv
`default_nettype none
// ============================================================================
//  Module      : bus_lane_steer
//  Description : Combinational byte-lane steering for big-endian sub-word
//                accesses: byte-enable generation, store-data replication
//                and load-data extraction with sign/zero extension.
//  Revision    : 1.0  initial release
// ============================================================================
module bus_lane_steer
  import codes::*;
(
  input  bus_size_t   i_size,
  input  logic        i_signed,
  input  logic [1:0]  i_offset,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rdata,
  output logic [3:0]  o_byteenable,
  output logic [31:0] o_writedata,
  output logic [31:0] o_rdata
);

  logic [7:0]  w_lane [4];
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Split the read bus into its four byte lanes
  generate
    for (genvar k = 0; k < 4; k++) begin : g_lane
      assign w_lane[k] = i_rdata[8*k +: 8];
    end
  endgenerate

  // Size/offset decode for enables, store lanes and extended load value
  always_comb begin
    o_byteenable = 4'b1111;
    o_writedata  = bswap32(i_wdata);
    o_rdata      = bswap32(i_rdata);
    w_byte       = w_lane[i_offset];
    w_half       = i_offset[1] ? {w_lane[2], w_lane[3]} : {w_lane[0], w_lane[1]};
    case (i_size)
      BYTE: begin
        o_byteenable = 4'b0001 << i_offset;
        o_writedata  = {4{i_wdata[7:0]}};
        o_rdata      = {{24{i_signed & w_byte[7]}}, w_byte};
      end
      HALF: begin
        o_byteenable = i_offset[1] ? 4'b1100 : 4'b0011;
        // even lane gets the high byte, odd lane the low byte
        o_writedata  = {2{i_wdata[7:0], i_wdata[15:8]}};
        o_rdata      = {{16{i_signed & w_half[15]}}, w_half};
      end
      default: begin
        o_byteenable = 4'b1111;
        o_writedata  = bswap32(i_wdata);
        o_rdata      = bswap32(i_rdata);
      end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mips_bus_unit.sv
`default_nettype none
// ============================================================================
//  Module      : mips_bus_unit
//  Description : Avalon-MM master bridging the multicycle MIPS core's fetch
//                and data ports onto one bus. Data has priority over fetch.
//                Honours waitrequest, steers big-endian sub-word accesses,
//                and aborts transfers stuck longer than TIMEOUT_CYCLES.
//  Options     : MIPS_BUS_ALIGN_CHECK_EN - reject misaligned requests with
//                bus_error_o and no bus cycle.
//  Revision    : 1.0  initial release
// ============================================================================
module mips_bus_unit
  import codes::*;
#(
  parameter int ADDR_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              reset_i,
  input  logic              fetch_req_i,
  input  logic [ADDR_W-1:0] fetch_addr_i,
  output logic              fetch_ready_o,
  output logic [31:0]       fetch_data_o,
  input  logic              mem_req_i,
  input  logic              mem_we_i,
  input  logic [1:0]        mem_size_i,
  input  logic              mem_signed_i,
  input  logic [ADDR_W-1:0] mem_addr_i,
  input  logic [31:0]       mem_wdata_i,
  output logic              mem_ready_o,
  output logic [31:0]       mem_rdata_o,
  output logic              bus_error_o,
  output logic              busy_o,
  output logic [ADDR_W-1:0] address_o,
  output logic              read_o,
  output logic              write_o,
  input  logic              waitrequest_i,
  output logic [31:0]       writedata_o,
  output logic [3:0]        byteenable_o,
  input  logic [31:0]       readdata_i
);

  // The counter holds completed wait cycles; abort fires on the last one
  localparam int c_CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
  localparam logic [c_CNT_W-1:0] c_TO_LAST =
      c_CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  bus_state_t          r_state, w_next;
  bus_src_t            r_src;
  logic [ADDR_W-1:0]   r_addr;
  bus_size_t           r_size;
  logic                r_signed;
  logic                r_we;
  logic [31:0]         r_wdata;
  logic [31:0]         r_rdata;
  logic                r_err;
  logic [c_CNT_W-1:0]  r_wait_cnt;

  logic                w_any_req;
  logic [ADDR_W-1:0]   w_req_addr;
  bus_size_t           w_req_size;
  logic                w_misaligned;
  logic                w_timeout;
  logic [3:0]          w_be;
  logic [31:0]         w_wd;
  logic [31:0]         w_load_data;

  assign w_any_req  = mem_req_i | fetch_req_i;
  assign w_req_addr = mem_req_i ? mem_addr_i : fetch_addr_i;
  assign w_req_size = mem_req_i ? bus_size_t'(mem_size_i) : WORD;
  assign w_timeout  = (TIMEOUT_CYCLES != 0) && waitrequest_i && (r_wait_cnt == c_TO_LAST);

`ifdef MIPS_BUS_ALIGN_CHECK_EN
  // Flag requests whose low address bits do not fit the access size
  always_comb begin
    w_misaligned = 1'b0;
    case (w_req_size)
      BYTE:    w_misaligned = 1'b0;
      HALF:    w_misaligned = w_req_addr[0];
      default: w_misaligned = |w_req_addr[1:0];
    endcase
  end
`else
  assign w_misaligned = 1'b0;
`endif

  bus_lane_steer u_steer (
    .i_size       (r_size),
    .i_signed     (r_signed),
    .i_offset     (r_addr[1:0]),
    .i_wdata      (r_wdata),
    .i_rdata      (readdata_i),
    .o_byteenable (w_be),
    .o_writedata  (w_wd),
    .o_rdata      (w_load_data)
  );

  // State register
  always_ff @(posedge clk) begin
    if (!reset_i) r_state <= IDLE;
    else          r_state <= w_next;
  end

  // Next-state decode and bus/core outputs, all derived from registered state
  always_comb begin
    w_next        = r_state;
    busy_o        = 1'b0;
    read_o        = 1'b0;
    write_o       = 1'b0;
    address_o     = '0;
    byteenable_o  = 4'b0000;
    writedata_o   = 32'h0;
    fetch_ready_o = 1'b0;
    fetch_data_o  = 32'h0;
    mem_ready_o   = 1'b0;
    mem_rdata_o   = 32'h0;
    bus_error_o   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_any_req) w_next = w_misaligned ? RESP : ACCESS;
      end
      ACCESS: begin
        busy_o       = 1'b1;
        read_o       = ~r_we;
        write_o      = r_we;
        address_o    = {r_addr[ADDR_W-1:2], 2'b00};
        byteenable_o = w_be;
        writedata_o  = r_we ? w_wd : 32'h0;
        if (!waitrequest_i || w_timeout) w_next = RESP;
      end
      RESP: begin
        busy_o        = 1'b1;
        fetch_ready_o = (r_src == SRC_FETCH);
        mem_ready_o   = (r_src == SRC_DATA);
        fetch_data_o  = (r_src == SRC_FETCH) ? r_rdata : 32'h0;
        mem_rdata_o   = (r_src == SRC_DATA)  ? r_rdata : 32'h0;
        bus_error_o   = r_err;
        w_next        = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Request capture in IDLE, wait counting and load capture in ACCESS
  always_ff @(posedge clk) begin
    if (!reset_i) begin
      r_src      <= SRC_FETCH;
      r_addr     <= '0;
      r_size     <= BYTE;
      r_signed   <= 1'b0;
      r_we       <= 1'b0;
      r_wdata    <= 32'h0;
      r_rdata    <= 32'h0;
      r_err      <= 1'b0;
      r_wait_cnt <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any_req) begin
            r_src      <= mem_req_i ? SRC_DATA : SRC_FETCH;
            r_addr     <= w_req_addr;
            r_size     <= w_req_size;
            r_signed   <= mem_req_i & mem_signed_i;
            r_we       <= mem_req_i & mem_we_i;
            r_wdata    <= mem_req_i ? mem_wdata_i : 32'h0;
            r_rdata    <= 32'h0;
            r_err      <= w_misaligned;
            r_wait_cnt <= '0;
          end
        end
        ACCESS: begin
          if (waitrequest_i) begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
            if (w_timeout) begin
              r_err   <= 1'b1;
              r_rdata <= 32'h0;
            end
          end else if (!r_we) begin
            r_rdata <= w_load_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mips_bus_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mips_bus_unit
//  Description : Directed self-checking bench for mips_bus_unit
//                (TIMEOUT_CYCLES = 4). Inputs change 1 ns after the rising
//                edge; outputs are checked in the same window.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mips_bus_unit;

  logic        clk;
  logic        reset_i;
  logic        fetch_req_i;
  logic [31:0] fetch_addr_i;
  logic        fetch_ready_o;
  logic [31:0] fetch_data_o;
  logic        mem_req_i;
  logic        mem_we_i;
  logic [1:0]  mem_size_i;
  logic        mem_signed_i;
  logic [31:0] mem_addr_i;
  logic [31:0] mem_wdata_i;
  logic        mem_ready_o;
  logic [31:0] mem_rdata_o;
  logic        bus_error_o;
  logic        busy_o;
  logic [31:0] address_o;
  logic        read_o;
  logic        write_o;
  logic        waitrequest_i;
  logic [31:0] writedata_o;
  logic [3:0]  byteenable_o;
  logic [31:0] readdata_i;

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;

  mips_bus_unit #(.ADDR_W(32), .TIMEOUT_CYCLES(4)) dut (
    .clk           (clk),
    .reset_i       (reset_i),
    .fetch_req_i   (fetch_req_i),
    .fetch_addr_i  (fetch_addr_i),
    .fetch_ready_o (fetch_ready_o),
    .fetch_data_o  (fetch_data_o),
    .mem_req_i     (mem_req_i),
    .mem_we_i      (mem_we_i),
    .mem_size_i    (mem_size_i),
    .mem_signed_i  (mem_signed_i),
    .mem_addr_i    (mem_addr_i),
    .mem_wdata_i   (mem_wdata_i),
    .mem_ready_o   (mem_ready_o),
    .mem_rdata_o   (mem_rdata_o),
    .bus_error_o   (bus_error_o),
    .busy_o        (busy_o),
    .address_o     (address_o),
    .read_o        (read_o),
    .write_o       (write_o),
    .waitrequest_i (waitrequest_i),
    .writedata_o   (writedata_o),
    .byteenable_o  (byteenable_o),
    .readdata_i    (readdata_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // One complete transfer with a given number of wait cycles
  task automatic xfer(input string tag, input bit is_fetch, input bit we,
                      input logic [1:0] sz, input bit sg, input logic [31:0] a,
                      input logic [31:0] wd, input logic [31:0] rd, input int waits,
                      input logic [3:0] be, input logic [31:0] bus_wd,
                      input logic [31:0] exp_rd);
    logic [31:0] exp_addr;
    exp_addr = {a[31:2], 2'b00};
    if (is_fetch) begin
      fetch_req_i  = 1'b1;
      fetch_addr_i = a;
    end else begin
      mem_req_i    = 1'b1;
      mem_we_i     = we;
      mem_size_i   = sz;
      mem_signed_i = sg;
      mem_addr_i   = a;
      mem_wdata_i  = wd;
    end
    readdata_i    = rd;
    waitrequest_i = 1'b0;
    tick();
    for (int i = 0; i <= waits; i++) begin
      chk({tag, " read_o"},  32'(read_o),  32'(!we));
      chk({tag, " write_o"}, 32'(write_o), 32'(we));
      chk({tag, " address"}, address_o, exp_addr);
      chk({tag, " be"}, 32'(byteenable_o), 32'(be));
      if (we) chk({tag, " wdata"}, writedata_o, bus_wd);
      chk({tag, " early rdy"}, 32'({fetch_ready_o, mem_ready_o}), 32'h0);
      waitrequest_i = (i < waits);
      tick();
    end
    if (is_fetch) begin
      chk({tag, " fetch_ready"}, 32'(fetch_ready_o), 32'h1);
      chk({tag, " fetch_data"}, fetch_data_o, exp_rd);
      chk({tag, " mem_ready"}, 32'(mem_ready_o), 32'h0);
    end else begin
      chk({tag, " mem_ready"}, 32'(mem_ready_o), 32'h1);
      if (!we) chk({tag, " mem_rdata"}, mem_rdata_o, exp_rd);
      chk({tag, " fetch_ready"}, 32'(fetch_ready_o), 32'h0);
    end
    chk({tag, " err"}, 32'(bus_error_o), 32'h0);
    chk({tag, " bus idle"}, 32'({read_o, write_o}), 32'h0);
    fetch_req_i = 1'b0;
    mem_req_i   = 1'b0;
    tick();
    chk({tag, " busy after"}, 32'(busy_o), 32'h0);
    chk({tag, " rdy pulse"}, 32'({fetch_ready_o, mem_ready_o}), 32'h0);
  endtask

  initial begin
    reset_i       = 1'b0;
    fetch_req_i   = 1'b0;
    fetch_addr_i  = 32'h0;
    mem_req_i     = 1'b0;
    mem_we_i      = 1'b0;
    mem_size_i    = 2'b00;
    mem_signed_i  = 1'b0;
    mem_addr_i    = 32'h0;
    mem_wdata_i   = 32'h0;
    waitrequest_i = 1'b0;
    readdata_i    = 32'h0;
    tick();
    tick();

    // Reset state
    chk("rst busy", 32'(busy_o), 32'h0);
    chk("rst rw", 32'({read_o, write_o}), 32'h0);
    chk("rst address", address_o, 32'h0);
    chk("rst be", 32'(byteenable_o), 32'h0);
    chk("rst wdata", writedata_o, 32'h0);
    chk("rst rdy/err", 32'({fetch_ready_o, mem_ready_o, bus_error_o}), 32'h0);
    chk("rst fetch_data", fetch_data_o, 32'h0);
    chk("rst mem_rdata", mem_rdata_o, 32'h0);
    reset_i = 1'b1;
    tick();

    // Directed transfers: fetch, byte/half/word loads and stores
    xfer("fetch4", 1'b1, 1'b0, 2'b10, 1'b0, 32'h4, 32'h0, 32'h78563412, 0, 4'b1111, 32'h0, 32'h12345678);
    xfer("lb_s", 1'b0, 1'b0, 2'b00, 1'b1, 32'h103, 32'h0, 32'h80000000, 0, 4'b1000, 32'h0, 32'hFFFFFF80);
    xfer("lb_u", 1'b0, 1'b0, 2'b00, 1'b0, 32'h103, 32'h0, 32'h80000000, 0, 4'b1000, 32'h0, 32'h00000080);
    xfer("sh_w3", 1'b0, 1'b1, 2'b01, 1'b0, 32'h202, 32'h0000ABCD, 32'h0, 3, 4'b1100, 32'hCDABCDAB, 32'h0);
    xfer("lh_s", 1'b0, 1'b0, 2'b01, 1'b1, 32'h200, 32'h0, 32'h000080FE, 1, 4'b0011, 32'h0, 32'hFFFFFE80);
    xfer("sw", 1'b0, 1'b1, 2'b10, 1'b0, 32'h10, 32'h11223344, 32'h0, 0, 4'b1111, 32'h44332211, 32'h0);
    xfer("sb1", 1'b0, 1'b1, 2'b00, 1'b0, 32'h1, 32'h0000005A, 32'h0, 0, 4'b0010, 32'h5A5A5A5A, 32'h0);
    xfer("lb_u1", 1'b0, 1'b0, 2'b00, 1'b0, 32'h1, 32'h0, 32'h0000C300, 2, 4'b0010, 32'h0, 32'h000000C3);

    // Simultaneous requests: data first, fetch three cycles later
    fetch_req_i   = 1'b1;
    fetch_addr_i  = 32'h40;
    mem_req_i     = 1'b1;
    mem_we_i      = 1'b0;
    mem_size_i    = 2'b10;
    mem_signed_i  = 1'b0;
    mem_addr_i    = 32'h80;
    waitrequest_i = 1'b0;
    readdata_i    = 32'h04030201;
    tick();
    chk("prio data addr", address_o, 32'h80);
    tick();
    chk("prio mem_ready", 32'({fetch_ready_o, mem_ready_o}), 32'h1);
    chk("prio mem_rdata", mem_rdata_o, 32'h01020304);
    mem_req_i  = 1'b0;
    readdata_i = 32'hDDCCBBAA;
    tick();
    chk("prio gap idle", 32'({busy_o, fetch_ready_o}), 32'h0);
    tick();
    chk("prio fetch addr", address_o, 32'h40);
    chk("prio fetch read", 32'(read_o), 32'h1);
    tick();
    chk("prio fetch_ready", 32'({fetch_ready_o, mem_ready_o}), 32'h2);
    chk("prio fetch_data", fetch_data_o, 32'hAABBCCDD);
    fetch_req_i = 1'b0;
    tick();

    // Timeout after four wait cycles
    mem_req_i     = 1'b1;
    mem_we_i      = 1'b0;
    mem_size_i    = 2'b10;
    mem_addr_i    = 32'h300;
    waitrequest_i = 1'b1;
    readdata_i    = 32'hFFFFFFFF;
    tick();
    for (int i = 0; i < 4; i++) begin
      chk("to read held", 32'(read_o), 32'h1);
      tick();
    end
    chk("to read drop", 32'(read_o), 32'h0);
    chk("to ready+err", 32'({mem_ready_o, bus_error_o}), 32'h3);
    chk("to rdata", mem_rdata_o, 32'h0);
    mem_req_i     = 1'b0;
    waitrequest_i = 1'b0;
    tick();
    chk("to after", 32'({busy_o, mem_ready_o, bus_error_o}), 32'h0);

    // Reset during ACCESS abandons the transfer
    mem_req_i     = 1'b1;
    mem_addr_i    = 32'h400;
    waitrequest_i = 1'b1;
    tick();
    chk("rsta read", 32'(read_o), 32'h1);
    reset_i = 1'b0;
    tick();
    chk("rsta read_o", 32'(read_o), 32'h0);
    chk("rsta busy", 32'(busy_o), 32'h0);
    mem_req_i     = 1'b0;
    reset_i       = 1'b1;
    waitrequest_i = 1'b0;
    tick();
    chk("rsta no ready", 32'({mem_ready_o, busy_o}), 32'h0);

    // Request dropped mid-transfer still completes
    mem_req_i     = 1'b1;
    mem_we_i      = 1'b0;
    mem_size_i    = 2'b00;
    mem_signed_i  = 1'b0;
    mem_addr_i    = 32'h2;
    readdata_i    = 32'h00AB0000;
    tick();
    mem_req_i     = 1'b0;
    waitrequest_i = 1'b1;
    tick();
    waitrequest_i = 1'b0;
    tick();
    chk("drop ready", 32'(mem_ready_o), 32'h1);
    chk("drop rdata", mem_rdata_o, 32'h000000AB);
    tick();

    // Misaligned word load
`ifdef MIPS_BUS_ALIGN_CHECK_EN
    mem_req_i  = 1'b1;
    mem_we_i   = 1'b0;
    mem_size_i = 2'b10;
    mem_addr_i = 32'h101;
    readdata_i = 32'h12345678;
    tick();
    chk("align ready+err", 32'({mem_ready_o, bus_error_o}), 32'h3);
    chk("align no read", 32'(read_o), 32'h0);
    chk("align rdata", mem_rdata_o, 32'h0);
    mem_req_i = 1'b0;
    tick();
    chk("align after", 32'(busy_o), 32'h0);
`else
    xfer("lw_mis", 1'b0, 1'b0, 2'b10, 1'b0, 32'h101, 32'h0, 32'h04030201, 0, 4'b1111, 32'h0, 32'h01020304);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mips_bus_unit.md
# mips_bus_unit

Avalon-MM bus interface unit between the multicycle MIPS core and memory. It arbitrates instruction-fetch and data requests onto one Avalon master port. It honours `waitrequest`, steers sub-word loads and stores onto byte lanes with big-endian byte order and sign or zero extension, and aborts stuck transfers with a timeout. It replaces the direct `address`/`read`/`write` wiring and endian swap in the CPU top level.

## Interface
- `ADDR_W`, 32: byte-address width.
- `TIMEOUT_CYCLES`, 255: maximum consecutive `waitrequest` cycles before abort; 0 disables the timeout.
- `clk` in 1: clock.
- `reset_i` in 1: reset, synchronous, active-low.
- `fetch_req_i` in 1: fetch request; level, held until `fetch_ready_o`.
- `fetch_addr_i` in ADDR_W: fetch byte address.
- `fetch_ready_o` out 1: one-cycle completion pulse.
- `fetch_data_o` out 32: instruction, big-endian; valid with `fetch_ready_o`.
- `mem_req_i` in 1: data request; level, held until `mem_ready_o`.
- `mem_we_i` in 1: 1 = store, 0 = load.
- `mem_size_i` in 2: `bus_size_t` (BYTE/HALF/WORD).
- `mem_signed_i` in 1: sign-extend sub-word loads.
- `mem_addr_i` in ADDR_W: data byte address.
- `mem_wdata_i` in 32: store data, right-justified.
- `mem_ready_o` out 1: one-cycle completion pulse.
- `mem_rdata_o` out 32: extended load data; valid with `mem_ready_o`.
- `bus_error_o` out 1: pulses with the ready pulse on timeout or misalignment.
- `busy_o` out 1: high in every state except IDLE.
- `address_o` out ADDR_W: word-aligned bus address, `{addr[ADDR_W-1:2],2'b00}`.
- `read_o` out 1: Avalon read.
- `write_o` out 1: Avalon write.
- `waitrequest_i` in 1: Avalon wait request.
- `writedata_o` out 32: lane-steered store data.
- `byteenable_o` out 4: Avalon byte enables.
- `readdata_i` in 32: Avalon read data; valid in the cycle `read_o` is high and `waitrequest_i` is low.

## Operation
- FSM states: IDLE, ACCESS, RESP.
- IDLE to ACCESS when any request is high. Data has priority over fetch when both are high. Address, size, sign, data and source are registered.
- ACCESS: `read_o`/`write_o` are held, together with constant address, byte enables and write data, while `waitrequest_i`=1. When `waitrequest_i`=0, load data is captured and the FSM moves to RESP.
- RESP: the owning ready pulses for one cycle with its data, then the FSM returns to IDLE.
- Lane k holds the byte at offset k. The big-endian word is {lane0,lane1,lane2,lane3}.
  - BYTE at offset k: `byteenable`=1<<k. Load = lane k, extended. Store = `wdata[7:0]` replicated to all lanes.
  - HALF at `addr[1]`=0: `byteenable`=0011, load {lane0,lane1}. HALF at `addr[1]`=1: `byteenable`=1100, load {lane2,lane3}. Store puts `wdata[15:8]` in the even lane and `wdata[7:0]` in the odd lane, duplicated to both halves.
  - WORD: `byteenable`=1111. Store lanes = {`wdata[31:24]`,…,`wdata[7:0]`} for lanes 0..3.
  - Fetch: always a WORD read.
- Timeout: a counter increments on every ACCESS cycle with `waitrequest_i`=1. At `TIMEOUT_CYCLES` the unit drops `read_o`/`write_o`, goes to RESP with `bus_error_o`=1, and returns rdata 0.
- A request dropped mid-transaction is ignored: the transfer completes and the ready pulse is still issued.

## Timing
- Reset values (while `reset_i`=0 at an edge): state IDLE; every output 0, including `address_o`, `byteenable_o`, `writedata_o` and both data outputs.
- Reset during ACCESS: `read_o`/`write_o` are low after the edge, the transfer is abandoned and no ready is issued.
- Minimum latency: request sampled in IDLE at edge N; bus signals asserted N+1..; ready at N+2 with zero waits. Each wait cycle adds 1.
- Back-to-back requests: the next request is accepted in IDLE at N+3, giving 3 cycles per transfer minimum.
- Ready pulses are exactly one cycle; `fetch_ready_o` and `mem_ready_o` are never high together.

## Configuration
- `MIPS_BUS_ALIGN_CHECK_EN` defined:
  - Misaligned requests (HALF with `addr[0]`=1, WORD or fetch with `addr[1:0]`≠0) issue no bus cycle.
  - IDLE goes to RESP directly; ready and `bus_error_o` pulse at N+1 with rdata 0.
- Undefined: low address bits are ignored. HALF uses `addr[1]`, WORD ignores `addr[1:0]`, and no error is raised.

## Structure
- Package `codes` gains `bus_size_t` (BYTE=2'b00, HALF=2'b01, WORD=2'b10) and `bus_state_t`.
- Sub-module `bus_lane_steer`: combinational byte-enable generation, store replication, and load extraction with extension.
- The FSM, timeout counter and registers stay in `mips_bus_unit`.

## Test plan
- Fetch 0x00000004, `readdata_i`=0x78563412, 0 waits → `fetch_ready_o` at N+2, `fetch_data_o`=0x12345678, `byteenable_o`=1111.
- Signed BYTE load 0x103, `readdata_i`=0x80000000 → `byteenable_o`=1000, `mem_rdata_o`=0xFFFFFF80. Same with unsigned → 0x00000080.
- HALF store 0x202, `wdata`=0x0000ABCD → `address_o`=0x200, `byteenable_o`=1100, `writedata_o`=0xCDABCDAB, `write_o` held through 3 wait cycles, ready at N+5.
- `fetch_req_i` and `mem_req_i` both high → data served first, then fetch; readies separated by at least 3 cycles.
- `TIMEOUT_CYCLES`=4, `waitrequest_i` stuck high → `read_o` drops after 4 wait cycles; ready and `bus_error_o` pulse together, rdata 0.
- `reset_i`=0 during ACCESS → next cycle `read_o`=0 and `busy_o`=0. With `MIPS_BUS_ALIGN_CHECK_EN`, WORD load 0x101 → error at N+1 and no `read_o`.
